seq_signed_mul: RTL
===================

# seq_signed_mul

Sequential signed multiplier for the ALU, the inverse operation of the divider datapath. It accepts two WIDTH-bit two's-complement operands on a start pulse and produces the full 2·WIDTH-bit signed product after a fixed latency. It uses a radix-2 shift-and-add loop on operand magnitudes, with two's-complement negation at entry and exit. It sits beside the divider behind the ALU operation decode and shares its start/busy/done handshake.

## Interface
- WIDTH, 16, operand width in bits; product is 2·WIDTH.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, signed.
- b  input  WIDTH  multiplier, signed.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when p is updated.
- p  output  2·WIDTH  signed product, held until the next done.
- ovf  output  1  present only with SMUL_OVF_EN; see Configuration.

## Operation
- States: IDLE, ABS, RUN, FIX.
- IDLE: if start=1, latch a and b, record sign = a[MSB] xor b[MSB], go to ABS. Otherwise stay.
- ABS: replace each negative operand by its two's-complement negation (invert and add 1). Treat both magnitudes as unsigned WIDTH bits, so -2^(WIDTH-1) gives magnitude 0x8000. Clear the accumulator and iteration counter. Go to RUN.
- RUN: WIDTH iterations, one per cycle.
  - If the multiplier LSB is 1, add the multiplicand magnitude into the accumulator's upper half.
  - Then shift {carry, acc, multiplier} right by 1.
  - The counter increments each cycle; after iteration WIDTH-1, go to FIX.
- FIX: if sign=1, p ← two's-complement negation of the 2·WIDTH-bit magnitude; else p ← magnitude. Pulse done and go to IDLE.
- A zero operand with a negative partner yields p=0; negation of 0 is 0, never 0x80000000.
- The magnitude product is at most 2^(2·WIDTH-2), so the 2·WIDTH-bit result never wraps.
- start while busy=1 is ignored; it is not queued.
- Operands a and b are don't-care after the acceptance edge.
- Async reset at any time forces the outputs to their reset values immediately:
  - state=IDLE, busy=0, done=0, p=0, ovf=0.
  - Internal registers are cleared.
  - Any operation in flight is discarded and produces no done.

## Timing
- Acceptance edge N (IDLE, start=1) → busy=1 from edge N until edge N+WIDTH+2.
- done=1 for exactly the one cycle following edge N+WIDTH+2, which is 18 cycles for WIDTH=16.
- p and ovf change only on that edge.
- busy=0 in the same cycle as done.
- start may be high during the done cycle and is accepted at the next edge, giving back-to-back throughput of one result per WIDTH+3 cycles.
- Latency is fixed and does not depend on operand values.

## Configuration
- SMUL_OVF_EN defined:
  - The ovf port exists.
  - ovf is registered at the FIX edge together with p.
  - ovf=1 when the product is not representable as a signed WIDTH-bit value, i.e. p[2·WIDTH-1:WIDTH-1] is not all-equal.
  - ovf holds until the next done; reset value 0.
- SMUL_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.

## Structure
- The shared ALU package holds:
  - the state encoding (IDLE, ABS, RUN, FIX);
  - the default WIDTH;
  - the counter width, clog2(WIDTH).
- One sub-module, twos_negate, parameterised by width: output = ~x + 1.
  - Instantiated at WIDTH twice in ABS.
  - Instantiated at 2·WIDTH once in FIX.
- The datapath and the FSM stay in seq_signed_mul.

## Test plan
- a=3, b=5, start pulse → done exactly 18 cycles after acceptance, p=0x0000000F, ovf=0.
- a=-7 (0xFFF9), b=6 → p=0xFFFFFFD6; a=0, b=-5 → p=0x00000000.
- a=0x8000, b=0x8000 → p=0x40000000, ovf=1; a=0x7FFF, b=0xFFFF → p=0xFFFF8001, ovf=0.
- a=300, b=300 → p=0x00015F90, ovf=1.
- Start accepted, then start re-pulsed with new operands at cycles 3 and 10 → single done with the first product; busy stays high throughout.
- rst asserted mid-RUN, at cycle 9 → busy=0, p=0, no done. After release, a new start with a=2, b=-3 yields p=0xFFFFFFFA after 18 cycles.

Source files
------------

// File: rtl/seq_signed_mul_pkg.sv
// Shared ALU package: multiplier state encoding, default operand width and counter sizing.
package seq_signed_mul_pkg;

  localparam int SMUL_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int SMUL_CNT_W = cnt_width(SMUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } smul_state_e;

endpackage

// File: rtl/seq_signed_mul_twos_negate.sv
// Two's-complement negation (~x + 1) at a configurable width.
module twos_negate #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  assign y_o = ~x_i + W'(1);

endmodule

// File: rtl/seq_signed_mul.sv
// Sequential signed multiplier: radix-2 shift-and-add on magnitudes, sign fixed up at exit.
// Optional overflow flag (product not representable in WIDTH signed bits) with SMUL_OVF_EN.
module seq_signed_mul
  import seq_signed_mul_pkg::*;
#(
  parameter int WIDTH = SMUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
`ifdef SMUL_OVF_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  smul_state_e      state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    p_q;

  logic [WIDTH-1:0] neg_mcand;
  logic [WIDTH-1:0] neg_mplier;
  logic [PW-1:0]    neg_prod;
  logic [WIDTH-1:0] addend_d;
  logic [WIDTH:0]   sum_d;
  logic [PW-1:0]    prod_d;

  twos_negate #(.W(WIDTH)) u_neg_a (.x_i(mcand_q),            .y_o(neg_mcand));
  twos_negate #(.W(WIDTH)) u_neg_b (.x_i(mplier_q),           .y_o(neg_mplier));
  twos_negate #(.W(PW))    u_neg_p (.x_i({acc_q, mplier_q}),  .y_o(neg_prod));

  // The carry out of the add lands in the accumulator MSB after the right shift.
  assign addend_d = mplier_q[0] ? mcand_q : '0;
  assign sum_d    = {1'b0, acc_q} + {1'b0, addend_d};
  assign prod_d   = sign_q ? neg_prod : {acc_q, mplier_q};

`ifdef SMUL_OVF_EN
  logic ovf_q;
  logic ovf_d;
  assign ovf_d = ~((&prod_d[PW-1:WIDTH-1]) | ~(|prod_d[PW-1:WIDTH-1]));
  assign ovf   = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
`ifdef SMUL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            busy_q   <= 1'b1;
            state_q  <= ABS;
          end
        end
        ABS: begin
          // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
          if (mcand_q[WIDTH-1])  mcand_q  <= neg_mcand;
          if (mplier_q[WIDTH-1]) mplier_q <= neg_mplier;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q    <= sum_d[WIDTH:1];
          mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          p_q     <= prod_d;
`ifdef SMUL_OVF_EN
          ovf_q   <= ovf_d;
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule
